// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and counter sizing.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A one-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a requester and the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bi;
  logic         busy;
  logic         done;
  logic [N-1:0] d;
  logic         bo;
  logic         ov;

  modport master (
    output start, a, b, bi,
    input  busy, done, d, bo, ov
  );

  modport slave (
    input  start, a, b, bi,
    output busy, done, d, bo, ov
  );
endinterface

// File: rtl/serial_subtractor_fa.sv
// Single-bit full adder shared with the combinational adder family.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_subtractor.sv
// d = a - b - bi computed LSB first, one bit per clock through a single full adder.
// Start accepted in IDLE/DONE only; done pulses N edges after the accepting edge.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  serial_subtractor_if.slave  bus
);

  localparam int            CW       = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t        state_q;
  logic [N-1:0]  a_sh_q;
  logic [N-1:0]  b_sh_q;
  logic [N-1:0]  d_q;
  logic [CW-1:0] cnt_q;
  logic          c_q;
  logic          a_msb_q;
  logic          b_msb_q;
  logic          busy_q;
  logic          done_q;
  logic          bo_q;
  logic          ov_q;

  logic [N-1:0]  a_sh_d;
  logic [N-1:0]  b_sh_d;
  logic [N-1:0]  d_d;
  logic          ov_d;
  logic          last_bit;
  logic          accept;
  logic          fa_s;
  logic          fa_co;

  // Subtraction as a + ~b + ~bi: the borrow lives inverted in the carry register.
  fa u_fa (
    .a  (a_sh_q[0]),
    .b  (~b_sh_q[0]),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    a_sh_d   = a_sh_q >> 1;
    b_sh_d   = b_sh_q >> 1;
    d_d      = (d_q >> 1) | (N'(fa_s) << (N - 1));
    ov_d     = (a_msb_q != b_msb_q) && (fa_s != a_msb_q);
    last_bit = (cnt_q == CNT_LAST);
    accept   = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            state_q <= S_RUN;
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            c_q     <= ~bus.bi;
            a_msb_q <= bus.a[N-1];
            b_msb_q <= bus.b[N-1];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            d_q     <= '0;
            bo_q    <= 1'b0;
            ov_q    <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh_q <= a_sh_d;
          b_sh_q <= b_sh_d;
          c_q    <= fa_co;
          d_q    <= d_d;
          // Counter parks at N-1 once the last bit is taken; only accept rewinds it.
          if (last_bit) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bo_q    <= ~fa_co;
            ov_q    <= ov_d;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.d    = d_q;
  assign bus.bo   = bo_q;
  assign bus.ov   = ov_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed checks of serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int N     = 4;
  localparam int HALF  = 5;
  localparam int MAXV  = (1 << N) - 1;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp   = 0;
  int   n_err   = 0;

  serial_subtractor_if #(.N(N)) bus ();

  serial_subtractor #(.N(N)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #HALF clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: plain integer subtraction, unsigned borrow and signed range test.
  function automatic void ref_sub(input int a, input int b, input int bi,
                                  output logic [N-1:0] d, output logic bo, output logic ov);
    int diff, sa, sb, sdiff;
    diff  = a - b - bi;
    d     = N'(diff);
    bo    = (diff < 0);
    sa    = (a >= (1 << (N - 1))) ? a - (1 << N) : a;
    sb    = (b >= (1 << (N - 1))) ? b - (1 << N) : b;
    sdiff = sa - sb - bi;
    ov    = (sdiff < -(1 << (N - 1))) || (sdiff > (1 << (N - 1)) - 1);
  endfunction

  // Drives one request and records what the DUT shows; comparisons are done by callers.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi,
                       output int lat, output logic [N-1:0] d, output logic bo,
                       output logic ov, output logic busy_acc, output logic [N-1:0] d_acc,
                       output logic busy_done, output logic done_next,
                       output logic [N-1:0] d_hold);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bi    = bi;
    step();
    bus.start = 1'b0;
    busy_acc  = bus.busy;
    d_acc     = bus.d;
    lat       = -1;
    for (int i = 1; i <= N + 4; i++) begin
      step();
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    d         = bus.d;
    bo        = bus.bo;
    ov        = bus.ov;
    busy_done = bus.busy;
    step();
    done_next = bus.done;
    d_hold    = bus.d;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bi    = 1'b0;
    reset_n   = 1'b0;
    repeat (2) step();
    n_cmp++;
    if ({bus.busy, bus.done, bus.d, bus.bo, bus.ov} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b d=%0d bo=%b ov=%b, want all 0",
               bus.busy, bus.done, bus.d, bus.bo, bus.ov);
    end
    reset_n = 1'b1;
    repeat (2) step();
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_directed();
    logic [N-1:0] va [4] = '{4'd7, 4'd3, 4'd7, 4'd0};
    logic [N-1:0] vb [4] = '{4'd3, 4'd7, 4'd8, 4'd0};
    logic         vbi[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [N-1:0] vd [4] = '{4'd4, 4'b1100, 4'b1111, 4'b1111};
    logic         vbo[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic         vov[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int lat;
    logic [N-1:0] d, d_acc, d_hold;
    logic bo, ov, busy_acc, busy_done, done_next;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], vbi[i], lat, d, bo, ov, busy_acc, d_acc, busy_done, done_next, d_hold);
      n_cmp++;
      if (lat != N) begin
        n_err++;
        $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, N);
      end
      n_cmp++;
      if ({d, bo, ov} !== {vd[i], vbo[i], vov[i]}) begin
        n_err++;
        $display("FAIL dir%0d_result: got d=%b bo=%b ov=%b want d=%b bo=%b ov=%b",
                 i, d, bo, ov, vd[i], vbo[i], vov[i]);
      end
      n_cmp++;
      if ({busy_acc, d_acc, busy_done} !== {1'b1, {N{1'b0}}, 1'b0}) begin
        n_err++;
        $display("FAIL dir%0d_busy: got busy@accept=%b d@accept=%b busy@done=%b want 1 0 0",
                 i, busy_acc, d_acc, busy_done);
      end
      n_cmp++;
      if (done_next !== 1'b0 || d_hold !== vd[i]) begin
        n_err++;
        $display("FAIL dir%0d_hold: got done=%b d=%b want done=0 d=%b",
                 i, done_next, d_hold, vd[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a1, b1, a2, b2, e1, e2;
    logic bi1, bi2, bo1, bo2, ov1, ov2;
    int lat1, cnt, lat2;
    a1 = N'($urandom_range(0, MAXV)); b1 = N'($urandom_range(0, MAXV)); bi1 = 1'($urandom_range(0, 1));
    ref_sub(int'(a1), int'(b1), int'(bi1), e1, bo1, ov1);
    do begin
      a2 = N'($urandom_range(0, MAXV)); b2 = N'($urandom_range(0, MAXV)); bi2 = 1'($urandom_range(0, 1));
      ref_sub(int'(a2), int'(b2), int'(bi2), e2, bo2, ov2);
    end while (e2 == e1);
    bus.start = 1'b1; bus.a = a1; bus.b = b1; bus.bi = bi1;
    step();
    // Start stays high with different operands for the whole RUN phase.
    bus.a = a2; bus.b = b2; bus.bi = bi2;
    lat1 = -1;
    for (int i = 1; i <= N + 4; i++) begin
      step();
      if (bus.done) begin
        lat1 = i;
        break;
      end
    end
    n_cmp++;
    if (lat1 != N) begin
      n_err++;
      $display("FAIL b2b_first_latency: got %0d want %0d", lat1, N);
    end
    n_cmp++;
    if ({bus.d, bus.bo, bus.ov} !== {e1, bo1, ov1}) begin
      n_err++;
      $display("FAIL b2b_ignore_start: got d=%b bo=%b ov=%b want d=%b bo=%b ov=%b",
               bus.d, bus.bo, bus.ov, e1, bo1, ov1);
    end
    step();
    bus.start = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_accept_in_done: got busy=%b done=%b want 1 0", bus.busy, bus.done);
    end
    cnt  = 1;
    lat2 = -1;
    for (int i = 0; i < N + 4; i++) begin
      step();
      cnt++;
      if (bus.done) begin
        lat2 = cnt;
        break;
      end
    end
    n_cmp++;
    if (lat2 != N + 1) begin
      n_err++;
      $display("FAIL b2b_second_spacing: got %0d want %0d", lat2, N + 1);
    end
    n_cmp++;
    if ({bus.d, bus.bo, bus.ov} !== {e2, bo2, ov2}) begin
      n_err++;
      $display("FAIL b2b_second_result: got d=%b bo=%b ov=%b want d=%b bo=%b ov=%b",
               bus.d, bus.bo, bus.ov, e2, bo2, ov2);
    end
    step();
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_done_pulse: got done=%b want 0", bus.done);
    end
  endtask

  task automatic test_async_reset();
    logic [N-1:0] a, b, e, d, d_acc, d_hold;
    logic bi, ebo, eov, bo, ov, busy_acc, busy_done, done_next, seen_done;
    int lat;
    // Pick operands whose two low difference bits are non-zero so d is non-zero mid-RUN.
    do begin
      a = N'($urandom_range(0, MAXV)); b = N'($urandom_range(0, MAXV)); bi = 1'($urandom_range(0, 1));
      ref_sub(int'(a), int'(b), int'(bi), e, ebo, eov);
    end while (e[1:0] == 2'b00);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.bi = bi;
    step();
    bus.start = 1'b0;
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.d, bus.bo, bus.ov} !== '0) begin
      n_err++;
      $display("FAIL async_reset_clear: got busy=%b done=%b d=%b bo=%b ov=%b want all 0",
               bus.busy, bus.done, bus.d, bus.bo, bus.ov);
    end
    step();
    reset_n   = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < N + 3; i++) begin
      step();
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_abort: got done/busy activity=%b want 0", seen_done);
    end
    do_op(a, b, bi, lat, d, bo, ov, busy_acc, d_acc, busy_done, done_next, d_hold);
    n_cmp++;
    if (lat != N || {d, bo, ov} !== {e, ebo, eov}) begin
      n_err++;
      $display("FAIL async_reset_recover: got lat=%0d d=%b bo=%b ov=%b want lat=%0d d=%b bo=%b ov=%b",
               lat, d, bo, ov, N, e, ebo, eov);
    end
  endtask

  task automatic test_exhaustive();
    logic [N-1:0] e, d, d_acc, d_hold;
    logic ebo, eov, bo, ov, busy_acc, busy_done, done_next;
    int lat;
    for (int a = 0; a <= MAXV; a++) begin
      for (int b = 0; b <= MAXV; b++) begin
        for (int bi = 0; bi < 2; bi++) begin
          ref_sub(a, b, bi, e, ebo, eov);
          do_op(N'(a), N'(b), 1'(bi), lat, d, bo, ov, busy_acc, d_acc, busy_done, done_next, d_hold);
          n_cmp++;
          if (lat != N || done_next !== 1'b0) begin
            n_err++;
            $display("FAIL exh_timing a=%0d b=%0d bi=%0d: got lat=%0d done_after=%b want lat=%0d done_after=0",
                     a, b, bi, lat, done_next, N);
          end
          n_cmp++;
          if ({d, bo, ov} !== {e, ebo, eov}) begin
            n_err++;
            $display("FAIL exh_result a=%0d b=%0d bi=%0d: got d=%0d bo=%b ov=%b want d=%0d bo=%b ov=%b",
                     a, b, bi, d, bo, ov, e, ebo, eov);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, e, d, d_acc, d_hold;
    logic bi, ebo, eov, bo, ov, busy_acc, busy_done, done_next;
    int lat, gap;
    for (int i = 0; i < 40; i++) begin
      a   = N'($urandom_range(0, MAXV));
      b   = N'($urandom_range(0, MAXV));
      bi  = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 2);
      repeat (gap) step();
      ref_sub(int'(a), int'(b), int'(bi), e, ebo, eov);
      do_op(a, b, bi, lat, d, bo, ov, busy_acc, d_acc, busy_done, done_next, d_hold);
      n_cmp++;
      if (lat != N || {d, bo, ov, d_hold} !== {e, ebo, eov, e}) begin
        n_err++;
        $display("FAIL rand%0d a=%0d b=%0d bi=%0d: got lat=%0d d=%0d bo=%b ov=%b hold=%0d want lat=%0d d=%0d bo=%b ov=%b",
                 i, a, b, bi, lat, d, bo, ov, d_hold, N, e, ebo, eov);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_async_reset();
    test_exhaustive();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "time limit");
  end

endmodule
